extension_pipe: RTL
===================

// Module: extension_pipe
// PURPOSE
//  Registered, flow-controlled operand extension stage for the pipeline datapath.
//  Extends immediates in four modes: zero, sign, lui, branch-offset.
//  Also aligns and extends sub-word load data in four modes: LB/LBU/LH/LHU.
//  One valid/ready slot in, one out. A 2-entry skid buffer absorbs downstream stalls.
//  Sits between ID/EX (immediate path) and MEM/WB (load path); instantiated once per use.
// PARAMETERS
//  DATA_W  32  result / load-word width; multiple of 16, >= IMM_W+2
//  IMM_W   16  immediate field width taken from in_src[IMM_W-1:0]
//  TAG_W   5   sideband tag (e.g. dest reg) carried alongside the result unchanged
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high
//  flush         in   1       sync pipeline flush; drops all held and incoming entries
//  in_valid      in   1       input entry present
//  in_ready      out  1       stage can accept this cycle
//  in_mode       in   3       ext_pkg::ext_mode_t
//  in_src        in   DATA_W  immediate (low IMM_W bits) or loaded word
//  in_off        in   2       byte offset for load modes (addr[1:0])
//  in_tag        in   TAG_W   sideband
//  out_valid     out  1       result present
//  out_ready     in   1       consumer accepts
//  out_data      out  DATA_W  extended result
//  out_tag       out  TAG_W   sideband of that result
//  out_misalign  out  1       LH/LHU with in_off[0]=1 (out_data forced 0)
// BEHAVIOUR
//  - Reset (sync, highest priority): out_valid=0, out_data=0, out_tag=0, out_misalign=0.
//    Skid empty. in_ready=0 while reset high; in_ready=1 the first cycle after reset.
//  - Modes: 000 ZERO = {0, imm}. 001 SIGN = {sext imm}. 010 LUI = imm << (DATA_W-IMM_W).
//    011 BR = sext(imm) << 2, truncated to DATA_W.
//  - Load modes (little-endian): 100 LB / 101 LBU use byte in_off (bits 8k+7:8k), sign/zero ext.
//    110 LH / 111 LHU use half in_off[1]. In_off ignored for modes 0xx.
//  - Misalign: LH/LHU with in_off[0]=1 -> out_data=0, out_misalign=1. Entry still passes; no stall.
//  - Accept when in_valid & in_ready. Latency 1: result visible on out_* the cycle after accept.
//  - Storage: main register (drives out_*) + one skid register.
//    in_ready = !skid_full (registered state, no comb path from out_ready).
//  - Per cycle (no flush), priorities:
//    main empty or out_ready: main <- skid if skid full, else the accepted input.
//      If skid was used and input accepted the same cycle, input -> skid.
//    main full and !out_ready: accepted input -> skid.
//  - Output held stable (data, tag, misalign) while out_valid & !out_ready.
//  - Ordering strictly FIFO; max 2 entries in flight; full throughput at out_ready=1.
//  - flush: next cycle out_valid=0, skid empty, in_ready=1. Input offered in the flush cycle is dropped.
//    Consumer handshake in flush cycle still counts. reset dominates flush.
//  - Undefined mode encodings do not exist (3-bit space fully used).
// STRUCTURE
//  - ext_pkg: ext_mode_t enum (EXT_ZERO..EXT_LHU = 3'b000..3'b111), MODE_W=3 localparam.
//  - Sub-module extension_core: purely combinational (mode, src, off) -> (data, misalign).
//    Parametrised DATA_W/IMM_W. Reused by any unregistered caller.
//  - extension_pipe: extension_core on the input side + main/skid registers + ready logic.
//    Skid stores computed results, not raw inputs.
// TESTING
//  1. SIGN imm 16'h8004, tag 3, out_ready=1 -> next cycle out_data=32'hFFFF8004, out_tag=3, misalign=0.
//  2. BR imm 16'hFFFF -> 32'hFFFFFFFC. LUI 16'h1234 -> 32'h12340000. ZERO 16'h8000 -> 32'h00008000.
//  3. LB src 32'h80FF7F01: off0 -> 32'h00000001; off2 -> FFFFFFFF. LBU off3 -> 32'h00000080.
//     LH off2 -> FFFF80FF. LHU off1 -> data 0, misalign=1.
//  4. Stall: stream 3 entries with out_ready=0. Entries A,B accepted; in_ready=0 with skid holding B.
//     Out holds A stable. Raise out_ready -> A,B,C emitted in order, no loss or duplicate.
//  5. Flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     The flushed input never appears.
//  6. Reset asserted mid-stream with both entries full -> out_valid=0, out_data=0, in_ready=0.
//     After deassert: in_ready=1 and a new entry emits with latency 1.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared types for the operand extension stage.
// Defines the 3-bit extension mode encoding used by extension_core/extension_pipe.
package ext_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        EXT_ZERO = 3'b000,
        EXT_SIGN = 3'b001,
        EXT_LUI  = 3'b010,
        EXT_BR   = 3'b011,
        EXT_LB   = 3'b100,
        EXT_LBU  = 3'b101,
        EXT_LH   = 3'b110,
        EXT_LHU  = 3'b111
    } ext_mode_t;

    function automatic logic is_half(input ext_mode_t m);
        return (m == EXT_LH) || (m == EXT_LHU);
    endfunction

endpackage

// File: rtl/extension_core.sv
// Combinational immediate / sub-word load extension.
// Ports: mode, src, off in; data (extended result), misalign (odd half offset) out.
import ext_pkg::*;

module extension_core #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] src,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    localparam int PAD = DATA_W - IMM_W;

    ext_mode_t         m;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_s;
    logic [7:0]        lbyte;
    logic [15:0]       lhalf;

    always_comb begin
        m     = ext_mode_t'(mode);
        imm   = src[IMM_W-1:0];
        imm_s = {{PAD{imm[IMM_W-1]}}, imm};
        lhalf = off[1] ? src[31:16] : src[15:0];
        lbyte = src[7:0];
        unique case (off)
            2'd0: lbyte = src[7:0];
            2'd1: lbyte = src[15:8];
            2'd2: lbyte = src[23:16];
            2'd3: lbyte = src[31:24];
        endcase
    end

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        unique case (m)
            EXT_ZERO: data = {{PAD{1'b0}}, imm};
            EXT_SIGN: data = imm_s;
            EXT_LUI:  data = {imm, {PAD{1'b0}}};
            EXT_BR:   data = {imm_s[DATA_W-3:0], 2'b00};
            EXT_LB:   data = {{(DATA_W-8){lbyte[7]}}, lbyte};
            EXT_LBU:  data = {{(DATA_W-8){1'b0}}, lbyte};
            EXT_LH,
            EXT_LHU: begin
                // odd half address: flag it and emit zero
                if (off[0]) begin
                    misalign = 1'b1;
                end else if (m == EXT_LH) begin
                    data = {{(DATA_W-16){lhalf[15]}}, lhalf};
                end else begin
                    data = {{(DATA_W-16){1'b0}}, lhalf};
                end
            end
        endcase
    end

endmodule

// File: rtl/extension_pipe.sv
// Registered valid/ready extension stage with a one-entry skid buffer.
// Ports: clk, reset, flush; in_* (valid/ready/mode/src/off/tag); out_* (valid/ready/data/tag/misalign).
import ext_pkg::*;

module extension_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_src,
    input  logic [1:0]        in_off,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign
);

    logic [DATA_W-1:0] ext_data;
    logic              ext_mis;

    extension_core #(
        .DATA_W(DATA_W),
        .IMM_W (IMM_W)
    ) u_core (
        .mode    (in_mode),
        .src     (in_src),
        .off     (in_off),
        .data    (ext_data),
        .misalign(ext_mis)
    );

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [TAG_W-1:0]  main_tag;
    logic              main_mis;
    logic              skid_full;
    logic [DATA_W-1:0] skid_data;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_mis;
    logic              accept;
    logic              advance;

    // ready depends only on held state, never on out_ready
    assign in_ready = !reset && !skid_full;
    assign accept   = in_valid && in_ready;
    assign advance  = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_tag   <= '0;
            main_mis   <= 1'b0;
            skid_full  <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            skid_mis   <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
        end else if (advance) begin
            if (skid_full) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_tag   <= skid_tag;
                main_mis   <= skid_mis;
                skid_full  <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= ext_data;
                main_tag   <= in_tag;
                main_mis   <= ext_mis;
            end else begin
                main_valid <= 1'b0;
            end
            // skid drained into main while a new entry arrives
            if (skid_full && accept) begin
                skid_full <= 1'b1;
                skid_data <= ext_data;
                skid_tag  <= in_tag;
                skid_mis  <= ext_mis;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_data <= ext_data;
            skid_tag  <= in_tag;
            skid_mis  <= ext_mis;
        end
    end

    assign out_valid    = main_valid;
    assign out_data     = main_data;
    assign out_tag      = main_tag;
    assign out_misalign = main_mis;

endmodule
